// File: rtl/stopwatch_ctrl_if.sv
// Button and status bundle between the stopwatch controller and its host / display driver.
// The preload pair lets the host load a start time while the stopwatch is idle.
interface stopwatch_ctrl_if;
    logic        btn_start_stop;
    logic        btn_lap_clear;
    logic        preload_vld;
    logic [23:0] preload_dat;
    logic        running;
    logic        tick;
    logic        wrap;
    logic        lap_active;
    logic [23:0] time_bcd;
    logic [23:0] display_bcd;

    modport master (
        output btn_start_stop, btn_lap_clear, preload_vld, preload_dat,
        input  running, tick, wrap, lap_active, time_bcd, display_bcd
    );

    modport slave (
        input  btn_start_stop, btn_lap_clear, preload_vld, preload_dat,
        output running, tick, wrap, lap_active, time_bcd, display_bcd
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/lap/clear FSM, centisecond prescaler and mm:ss.cc BCD time; press -> state in 1 cycle, tick -> time in 1 cycle.
// No backpressure: buttons are debounced levels sampled every cycle and every output is a registered status.
module stopwatch_ctrl #(
    parameter int DIVISOR    = 1000000,
    parameter int PRESCALE_W = 20
) (
    input  logic            clock_in,
    input  logic            reset,
    stopwatch_ctrl_if.slave sw
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        LAP   = 2'd2,
        PAUSE = 2'd3
    } state_e;

    localparam logic [PRESCALE_W-1:0] PRESC_LAST = PRESCALE_W'(DIVISOR - 1);
    localparam logic [23:0]           TIME_LAST  = 24'h595999;

    state_e                  state_q, state_d;
    logic                    ss_q, lc_q;
    logic [PRESCALE_W-1:0]   presc_q, presc_d;
    logic                    tick_q, tick_d;
    logic                    wrap_q, wrap_d;
    logic [23:0]             time_q, time_d;
    logic [23:0]             disp_q, disp_d;
    logic                    running_q, running_d;
    logic                    lap_q, lap_d;

    logic                    ss_press;
    logic                    lc_press;
    logic                    counting;
    logic                    clear;

    // Digit order from LSB: c0, c1, s0, s1, m0, m1; tens of seconds/minutes stop at 5.
    function automatic logic [3:0] digit_max(input int idx);
        return (idx == 3 || idx == 5) ? 4'd5 : 4'd9;
    endfunction

    function automatic logic [23:0] bcd_inc(input logic [23:0] t);
        logic [23:0] r;
        logic        carry;
        r     = t;
        carry = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (carry) begin
                if (t[i*4 +: 4] == digit_max(i)) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = t[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        ss_press = sw.btn_start_stop & ~ss_q;
        lc_press = sw.btn_lap_clear & ~lc_q & ~ss_press;
        counting = (state_q == RUN) || (state_q == LAP);
        state_d  = state_q;
        clear    = 1'b0;

        case (state_q)
            IDLE: begin
                if (ss_press) state_d = RUN;
            end
            RUN: begin
                if (ss_press)      state_d = PAUSE;
                else if (lc_press) state_d = LAP;
            end
            LAP: begin
                if (ss_press)      state_d = PAUSE;
                else if (lc_press) state_d = RUN;
            end
            PAUSE: begin
                if (ss_press) begin
                    state_d = RUN;
                end else if (lc_press) begin
                    state_d = IDLE;
                    clear   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Tick decision follows the current state, so a stop on the last count still ticks.
        presc_d = presc_q;
        tick_d  = 1'b0;
        if (clear) begin
            presc_d = '0;
        end else if (counting) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                tick_d  = 1'b1;
            end else begin
                presc_d = presc_q + PRESCALE_W'(1);
            end
        end

        time_d = time_q;
        wrap_d = 1'b0;
        if (clear) begin
            time_d = '0;
        end else if (tick_q) begin
            time_d = bcd_inc(time_q);
            wrap_d = (time_q == TIME_LAST);
        end else if (state_q == IDLE && sw.preload_vld) begin
            time_d = sw.preload_dat;
        end

        // Entering LAP freezes the pre-increment time; staying in LAP holds it.
        if (state_d == LAP) begin
            disp_d = (state_q == LAP) ? disp_q : time_q;
        end else begin
            disp_d = time_d;
        end

        running_d = (state_d == RUN) || (state_d == LAP);
        lap_d     = (state_d == LAP);
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q   <= IDLE;
            ss_q      <= 1'b1;
            lc_q      <= 1'b1;
            presc_q   <= '0;
            tick_q    <= 1'b0;
            wrap_q    <= 1'b0;
            time_q    <= '0;
            disp_q    <= '0;
            running_q <= 1'b0;
            lap_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ss_q      <= sw.btn_start_stop;
            lc_q      <= sw.btn_lap_clear;
            presc_q   <= presc_d;
            tick_q    <= tick_d;
            wrap_q    <= wrap_d;
            time_q    <= time_d;
            disp_q    <= disp_d;
            running_q <= running_d;
            lap_q     <= lap_d;
        end
    end

    assign sw.running     = running_q;
    assign sw.tick        = tick_q;
    assign sw.wrap        = wrap_q;
    assign sw.lap_active  = lap_q;
    assign sw.time_bcd    = time_q;
    assign sw.display_bcd = disp_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Random and directed stimulus for stopwatch_ctrl, checked every cycle against a centisecond-integer model.
module tb_stopwatch_ctrl;

    localparam int DIV   = 4;
    localparam int TOTAL = 360000;

    logic clock_in;
    logic reset;

    stopwatch_ctrl_if sw ();

    stopwatch_ctrl #(.DIVISOR(DIV), .PRESCALE_W(4)) dut (
        .clock_in (clock_in),
        .reset    (reset),
        .sw       (sw.slave)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: time as an integer count of centiseconds, modes as plain flags.
    bit model_ok = 0;
    bit m_run, m_lap, m_paused, m_tick, m_wrap, prev_ss, prev_lc;
    int m_cs, m_frozen, m_phase;
    bit e_ss, e_lc, e_idle, e_old_tick;
    int e_old_cs;

    function automatic logic [23:0] to_bcd(input int cs);
        int m, s, c;
        m = cs / 6000;
        s = (cs / 100) % 60;
        c = cs % 100;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    function automatic int from_bcd(input logic [23:0] b);
        return (int'(b[23:20]) * 10 + int'(b[19:16])) * 6000 +
               (int'(b[15:12]) * 10 + int'(b[11:8])) * 100 +
               int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    always @(posedge clock_in) begin
        if (reset) begin
            m_run = 0; m_lap = 0; m_paused = 0; m_tick = 0; m_wrap = 0;
            m_cs = 0; m_frozen = 0; m_phase = 0;
            prev_ss = 1; prev_lc = 1;
            model_ok = 1;
        end else if (model_ok) begin
            e_ss = sw.btn_start_stop && !prev_ss;
            e_lc = sw.btn_lap_clear && !prev_lc && !e_ss;
            prev_ss = sw.btn_start_stop;
            prev_lc = sw.btn_lap_clear;
            e_old_cs   = m_cs;
            e_old_tick = m_tick;
            e_idle     = !m_run && !m_paused;
            m_tick = 0;
            m_wrap = 0;
            if (m_run) begin
                if (m_phase == DIV - 1) begin
                    m_tick  = 1;
                    m_phase = 0;
                end else begin
                    m_phase++;
                end
            end
            if (m_paused && e_lc) begin
                m_cs = 0;
                m_phase = 0;
            end else if (e_old_tick) begin
                m_wrap = (e_old_cs == TOTAL - 1);
                m_cs   = (e_old_cs + 1) % TOTAL;
            end else if (e_idle && sw.preload_vld) begin
                m_cs = from_bcd(sw.preload_dat);
            end
            if (e_idle) begin
                if (e_ss) m_run = 1;
            end else if (m_paused) begin
                if (e_ss) begin m_paused = 0; m_run = 1; end
                else if (e_lc) m_paused = 0;
            end else if (m_lap) begin
                if (e_ss) begin m_lap = 0; m_run = 0; m_paused = 1; end
                else if (e_lc) m_lap = 0;
            end else begin
                if (e_ss) begin m_run = 0; m_paused = 1; end
                else if (e_lc) begin m_lap = 1; m_frozen = e_old_cs; end
            end
        end
    end

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h, required %h", name, $time, act, exp);
        end
    endtask

    always @(posedge clock_in) begin
        #1;
        if (model_ok) begin
            check("model_running", 24'(sw.running), 24'(m_run));
            check("model_lap_active", 24'(sw.lap_active), 24'(m_lap));
            check("model_tick", 24'(sw.tick), 24'(m_tick));
            check("model_wrap", 24'(sw.wrap), 24'(m_wrap));
            check("model_time_bcd", sw.time_bcd, to_bcd(m_cs));
            check("model_display_bcd", sw.display_bcd, m_lap ? to_bcd(m_frozen) : to_bcd(m_cs));
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clock_in);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        sw.btn_start_stop = 1'b0;
        sw.btn_lap_clear  = 1'b0;
        step();
    endtask

    task automatic press_ss();
        sw.btn_start_stop = 1'b1;
        step();
        sw.btn_start_stop = 1'b0;
    endtask

    task automatic press_lc();
        sw.btn_lap_clear = 1'b1;
        step();
        sw.btn_lap_clear = 1'b0;
    endtask

    int k;

    initial begin
        reset = 1'b1;
        sw.btn_start_stop = 1'b0;
        sw.btn_lap_clear  = 1'b0;
        sw.preload_vld    = 1'b0;
        sw.preload_dat    = '0;

        // Reset values, start, tick spacing, one second after 100 ticks.
        do_reset();
        check("reset_time", sw.time_bcd, 24'h000000);
        check("reset_running", 24'(sw.running), 24'h0);
        press_ss();
        check("start_running", 24'(sw.running), 24'h1);
        k = 0;
        while (sw.tick !== 1'b1 && k < 20) begin step(); k++; end
        check("first_tick_cycles", 24'(k), 24'd4);
        while (sw.time_bcd !== 24'h000100 && k < 600) begin step(); k++; end
        check("one_second_cycles", 24'(k), 24'd401);

        // Pause at 37 keeps time and partial centisecond.
        do_reset();
        press_ss();
        k = 0;
        while (sw.time_bcd !== 24'h000037 && k < 400) begin step(); k++; end
        press_ss();
        step(50);
        check("pause_time", sw.time_bcd, 24'h000037);
        check("pause_running", 24'(sw.running), 24'h0);
        press_ss();
        k = 0;
        while (sw.tick !== 1'b1 && k < 20) begin step(); k++; end
        check("resume_tick_cycles", 24'(k), 24'd2);

        // Lap freeze at 01.05 while time runs on.
        do_reset();
        press_ss();
        k = 0;
        while (sw.time_bcd !== 24'h000105 && k < 600) begin step(); k++; end
        press_lc();
        check("lap_active", 24'(sw.lap_active), 24'h1);
        check("lap_display", sw.display_bcd, 24'h000105);
        step(20);
        check("lap_display_held", sw.display_bcd, 24'h000105);
        check("lap_time_runs", sw.time_bcd, 24'h000110);
        press_lc();
        check("unlap_active", 24'(sw.lap_active), 24'h0);
        check("unlap_display", sw.display_bcd, 24'h000110);

        // Rollover from 59:59.98.
        do_reset();
        sw.preload_vld = 1'b1;
        sw.preload_dat = 24'h595998;
        step();
        sw.preload_vld = 1'b0;
        check("preload_time", sw.time_bcd, 24'h595998);
        press_ss();
        k = 0;
        while (sw.time_bcd !== 24'h595999 && k < 20) begin step(); k++; end
        check("pre_wrap_time", sw.time_bcd, 24'h595999);
        k = 0;
        while (sw.time_bcd === 24'h595999 && k < 20) begin step(); k++; end
        check("wrap_time", sw.time_bcd, 24'h000000);
        check("wrap_pulse", 24'(sw.wrap), 24'h1);
        step();
        check("wrap_one_cycle", 24'(sw.wrap), 24'h0);

        // Both presses together, then clear from pause.
        do_reset();
        press_ss();
        step(6);
        sw.btn_start_stop = 1'b1;
        sw.btn_lap_clear  = 1'b1;
        step();
        sw.btn_start_stop = 1'b0;
        sw.btn_lap_clear  = 1'b0;
        check("both_running", 24'(sw.running), 24'h0);
        check("both_no_lap", 24'(sw.lap_active), 24'h0);
        step();
        press_lc();
        check("clear_time", sw.time_bcd, 24'h000000);
        check("clear_running", 24'(sw.running), 24'h0);

        // Button held through reset gives no press.
        sw.btn_start_stop = 1'b1;
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        step(5);
        check("held_no_start", 24'(sw.running), 24'h0);
        sw.btn_start_stop = 1'b0;
        step();
        press_ss();
        check("held_then_start", 24'(sw.running), 24'h1);
        step(10);
        reset = 1'b1;
        step();
        check("midrun_reset_running", 24'(sw.running), 24'h0);
        check("midrun_reset_tick", 24'(sw.tick), 24'h0);
        check("midrun_reset_time", sw.time_bcd, 24'h000000);
        check("midrun_reset_display", sw.display_bcd, 24'h000000);
        reset = 1'b0;
        step();

        // Random buttons, preloads and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) sw.btn_start_stop = ~sw.btn_start_stop;
            if ($urandom_range(0, 7) == 0) sw.btn_lap_clear  = ~sw.btn_lap_clear;
            if ($urandom_range(0, 39) == 0) begin
                sw.btn_start_stop = 1'b1;
                sw.btn_lap_clear  = 1'b1;
            end
            sw.preload_vld = ($urandom_range(0, 9) == 0);
            sw.preload_dat = ($urandom_range(0, 1) == 0) ? to_bcd(int'($urandom_range(TOTAL - 10, TOTAL - 1)))
                                                         : to_bcd(int'($urandom_range(0, TOTAL - 1)));
            reset = ($urandom_range(0, 699) == 0);
            step();
        end
        reset = 1'b0;
        sw.preload_vld = 1'b0;
        step(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
